cam_capture: RTL and testbench

- Writer end of the frame-buffer interface: captures an RGB565 QVGA stream from the OV7670-class camera and writes it into the 320x240 dual-port frame buffer.
- The VGA scan-out block reads the other port of that buffer with 17-bit linear addresses, 0 = top-left, row-major.
- Runs entirely in the clk25 domain: camera PCLK/HREF/VSYNC/D are sampled asynchronous inputs; camera PCLK must be at most clk25/4.

---
 rtl/cam_pkg.sv | 31 +++
 rtl/cam_sync_edge.sv | 35 +++
 rtl/cam_capture.sv | 147 ++++++++++++++
 tb/tb_cam_capture.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path and the VGA scan-out block:
// FSM state encoding, frame-buffer geometry and RGB565 field positions.
package cam_pkg;

  localparam int CAM_H_PIX   = 320;
  localparam int CAM_V_LINES = 240;
  localparam int CAM_ADDR_W  = 17;
  localparam int FB_DEPTH    = CAM_H_PIX * CAM_V_LINES;

  // RGB565 layout shared with the VGA reader.
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } cam_state_t;

  // The camera sends the high byte of each RGB565 pixel first.
  function automatic logic [15:0] rgb565_pack(input logic [7:0] first_byte,
                                              input logic [7:0] second_byte);
    return {first_byte, second_byte};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-flop synchronizer for one asynchronous camera control line, with
// single-cycle rise/fall strobes derived from the synchronized level.
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchronizer chain and keep one cycle of
  // history of the synchronized level for edge detection.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the value from before the edge, regardless of statement order.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: turns an OV7670-style RGB565 byte stream into linear
// frame-buffer writes, one pixel per two camera bytes, row-major from 0.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_PIX       = CAM_H_PIX,
  parameter int V_LINES     = CAM_V_LINES,
  parameter int ADDR_W      = CAM_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_data,
  input  logic              arm,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              fb_we,
  output logic              frame_done,
  output logic              capturing,
  output logic              overrun
);

  localparam int DEPTH  = H_PIX * V_LINES;
  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);

  cam_state_t state_q, state_d;

  logic pclk_q, samp, pclk_fall;
  logic href_s, href_rise, href_fall;
  logic vsync_q, vsync_rise, vsync_fall;

  logic [SYNC_STAGES:0][7:0] data_pipe;
  logic [7:0]                data_s;

  logic [PTR_W-1:0]  wr_ptr;
  logic [LINE_W-1:0] line_cnt;
  logic              phase;
  logic [7:0]        hi_byte;
  logic              room_ok;

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk25 (clk25), .rst_n (rst_n), .d (cam_pclk),
    .q (pclk_q), .rise (samp), .fall (pclk_fall)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
    .clk25 (clk25), .rst_n (rst_n), .d (cam_href),
    .q (href_s), .rise (href_rise), .fall (href_fall)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk25 (clk25), .rst_n (rst_n), .d (cam_vsync),
    .q (vsync_q), .rise (vsync_rise), .fall (vsync_fall)
  );

  // Only the pclk rising edge and the href/vsync strobes drive the design.
  logic unused_sync;
  assign unused_sync = &{1'b0, pclk_q, pclk_fall, href_rise, vsync_q};

  // Data runs one flop deeper than pclk so the byte is settled when samp fires.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      data_pipe <= '0;
    end else begin
      data_pipe <= {data_pipe[SYNC_STAGES-1:0], cam_data};
    end
  end

  assign data_s = data_pipe[SYNC_STAGES];

  // State register.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: arm gates the start of a frame, never its completion.
  // NOTE: next-state starts from a default so no path leaves state_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (arm && vsync_rise) state_d = S_WAIT;
      S_WAIT:   if (vsync_fall)        state_d = S_ACTIVE;
      S_ACTIVE: if (vsync_rise)        state_d = S_DONE;
      S_DONE:   state_d = arm ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign capturing = (state_q == S_ACTIVE);

  // A pixel is stored only inside the visible line range and below the cap.
  assign room_ok = (line_cnt < LINE_W'(V_LINES)) && (wr_ptr < PTR_W'(DEPTH));

  // Byte pairing, address/line tracking, write strobe and status flags.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr    <= '0;
      fb_data    <= '0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      line_cnt   <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= (state_q == S_DONE) && (wr_ptr == PTR_W'(DEPTH));
      if (state_q == S_WAIT && vsync_fall) begin
        wr_ptr   <= '0;
        line_cnt <= '0;
        phase    <= 1'b0;
      end else if (state_q == S_ACTIVE) begin
        if (href_fall) begin
          // End of line: an unpaired trailing byte is abandoned here.
          phase <= 1'b0;
          if (line_cnt < LINE_W'(V_LINES)) line_cnt <= line_cnt + LINE_W'(1);
        end else if (samp && href_s) begin
          if (!phase) begin
            hi_byte <= data_s;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (room_ok) begin
              fb_we   <= 1'b1;
              fb_addr <= ADDR_W'(wr_ptr);
              fb_data <= rgb565_pack(hi_byte, data_s);
              wr_ptr  <= wr_ptr + PTR_W'(1);
            end else begin
              overrun <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 8x4 frame so every scenario
// stays short; expected writes come from a byte-level model of the camera.
module tb_cam_capture;

  localparam int H      = 8;
  localparam int V      = 4;
  localparam int DEPTH  = H * V;
  localparam int BYTES  = 2 * H;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_vsync = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        arm = 1'b0;
  logic [16:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_we;
  logic        frame_done;
  logic        capturing;
  logic        overrun;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_we   = 0;
  int   n_done = 0;
  exp_t exp_q[$];
  logic [15:0] mem [DEPTH];

  // Camera-side model state.
  logic       m_active = 1'b0;
  int         m_ptr = 0;
  int         m_line = 0;
  logic       m_overrun = 1'b0;
  logic [7:0] byte_seq = 8'h00;

  int we_mark;
  int done_mark;

  cam_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(17), .SYNC_STAGES(2)) dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .cam_pclk   (cam_pclk),
    .cam_href   (cam_href),
    .cam_vsync  (cam_vsync),
    .cam_data   (cam_data),
    .arm        (arm),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .frame_done (frame_done),
    .capturing  (capturing),
    .overrun    (overrun)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every write is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk25);
      if (frame_done === 1'b1) n_done++;
      if (fb_we === 1'b1) begin
        n_we++;
        if (fb_addr < 17'(DEPTH)) mem[fb_addr[4:0]] = fb_data;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_write: observed write addr %0d data %0h, expected no write",
                 fb_addr, fb_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", {15'd0, fb_addr}, {15'd0, e.addr});
          check("wr_data", {16'd0, fb_data}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic model_pixel(input logic [15:0] px);
    if (m_active) begin
      if (m_line < V && m_ptr < DEPTH) begin
        exp_q.push_back('{addr: 17'(m_ptr), data: px});
        m_ptr++;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  task automatic start_model_frame();
    m_ptr    = 0;
    m_line   = 0;
    byte_seq = 8'h00;
  endtask

  // One camera byte: data changes while pclk is low, pclk = clk25/4.
  task automatic cam_byte(input logic [7:0] b);
    @(negedge clk25);
    cam_data = b;
    cam_pclk = 1'b0;
    @(negedge clk25);
    @(negedge clk25);
    cam_pclk = 1'b1;
    @(negedge clk25);
  endtask

  task automatic cam_line(input int nbytes);
    logic [7:0] hi;
    logic [7:0] b;
    hi = 8'h00;
    @(negedge clk25);
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      b = byte_seq;
      byte_seq = byte_seq + 8'd1;
      cam_byte(b);
      if (i % 2 == 1) model_pixel({hi, b});
      else            hi = b;
    end
    @(negedge clk25);
    cam_href = 1'b0;
    repeat (4) @(negedge clk25);
    m_line++;
  endtask

  task automatic vsync_pulse();
    @(negedge clk25);
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk25);
    cam_vsync = 1'b0;
    repeat (8) @(negedge clk25);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk25);
    check("rst_fb_addr", {15'd0, fb_addr}, 32'd0);
    check("rst_fb_data", {16'd0, fb_data}, 32'd0);
    check("rst_fb_we", {31'd0, fb_we}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_capturing", {31'd0, capturing}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk25);

    // 1. Full frame.
    arm = 1'b1;
    vsync_pulse();
    m_active = 1'b1;
    start_model_frame();
    check("t1_capturing", {31'd0, capturing}, 32'd1);
    for (int l = 0; l < V; l++) cam_line(BYTES);
    vsync_pulse();
    check("t1_drained", exp_q.size(), 32'd0);
    check("t1_write_count", n_we, DEPTH);
    check("t1_frame_done", n_done, 32'd1);
    check("t1_overrun", {31'd0, overrun}, {31'd0, m_overrun});
    check("t1_pixel5", {16'd0, mem[5]}, 32'h0000_0A0B);
    check("t1_last_addr", {15'd0, fb_addr}, DEPTH - 1);

    // 2. Odd-byte first line; the frame started with the closing vsync above.
    start_model_frame();
    we_mark = n_we;
    cam_line(BYTES + 1);
    repeat (4) @(negedge clk25);
    check("t2_line0_writes", n_we - we_mark, H);
    check("t2_line0_last_addr", {15'd0, fb_addr}, H - 1);
    for (int l = 1; l < V; l++) cam_line(BYTES);
    done_mark = n_done;
    vsync_pulse();
    check("t2_drained", exp_q.size(), 32'd0);
    check("t2_frame_done", n_done - done_mark, 32'd1);

    // 3. Overlong frame: one extra line beyond the cap.
    start_model_frame();
    for (int l = 0; l < V + 1; l++) cam_line(BYTES);
    repeat (4) @(negedge clk25);
    check("t3_drained", exp_q.size(), 32'd0);
    check("t3_last_addr", {15'd0, fb_addr}, DEPTH - 1);
    check("t3_overrun", {31'd0, overrun}, {31'd0, m_overrun});

    // 4b. Next frame (started by the vsync below); arm dropped mid-frame.
    vsync_pulse();
    start_model_frame();
    cam_line(BYTES);
    arm = 1'b0;
    for (int l = 1; l < V; l++) cam_line(BYTES);
    done_mark = n_done;
    vsync_pulse();
    m_active = 1'b0;
    check("t4b_drained", exp_q.size(), 32'd0);
    check("t4b_frame_done", n_done - done_mark, 32'd1);
    check("t4b_idle", {31'd0, capturing}, 32'd0);

    // 4a. arm low through the vsync pulse, raised afterwards: no capture.
    we_mark = n_we;
    vsync_pulse();
    arm = 1'b1;
    cam_line(BYTES);
    cam_line(BYTES);
    check("t4a_no_writes", n_we - we_mark, 32'd0);
    check("t4a_not_capturing", {31'd0, capturing}, 32'd0);

    // 5. Reset in the middle of line 1.
    vsync_pulse();
    m_active = 1'b1;
    start_model_frame();
    cam_line(BYTES);
    @(negedge clk25);
    cam_href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = byte_seq;
      byte_seq = byte_seq + 8'd1;
      cam_byte(b);
      if (i == 1) model_pixel({b - 8'd1, b});
      if (i == 3) model_pixel({b - 8'd1, b});
    end
    repeat (8) @(negedge clk25);
    check("t5_pre_reset_drained", exp_q.size(), 32'd0);
    check("t5_pre_reset_addr", {15'd0, fb_addr}, H + 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_fb_addr", {15'd0, fb_addr}, 32'd0);
    check("t5_rst_fb_data", {16'd0, fb_data}, 32'd0);
    check("t5_rst_fb_we", {31'd0, fb_we}, 32'd0);
    check("t5_rst_capturing", {31'd0, capturing}, 32'd0);
    check("t5_rst_overrun", {31'd0, overrun}, 32'd0);
    m_active = 1'b0;
    m_overrun = 1'b0;
    repeat (3) @(negedge clk25);
    cam_href = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk25);
    we_mark = n_we;
    cam_line(BYTES);
    check("t5_no_capture_before_vsync", n_we - we_mark, 32'd0);

    // 6. Short frame: vsync after half the lines, then a full frame from 0.
    vsync_pulse();
    m_active = 1'b1;
    start_model_frame();
    we_mark = n_we;
    for (int l = 0; l < V / 2; l++) cam_line(BYTES);
    done_mark = n_done;
    vsync_pulse();
    check("t6_short_writes", n_we - we_mark, DEPTH / 2);
    check("t6_no_frame_done", n_done - done_mark, 32'd0);
    start_model_frame();
    for (int l = 0; l < V; l++) cam_line(BYTES);
    arm = 1'b0;
    done_mark = n_done;
    vsync_pulse();
    m_active = 1'b0;
    check("t6_full_frame_done", n_done - done_mark, 32'd1);
    check("t6_drained", exp_q.size(), 32'd0);
    check("t6_overrun", {31'd0, overrun}, {31'd0, m_overrun});
    check("t6_idle", {31'd0, capturing}, 32'd0);

    repeat (4) @(negedge clk25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
